// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM front end: FSM states, port owner encoding,
// and the wait-state counter width helper.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } owner_t;

   // Counter must hold WAIT_CYCLES; never narrower than one bit.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the two requesters (CPU MAR/MDR path, I/O loader)
// and the RAM arbiter. master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);

   logic              req0_valid;
   logic              req0_write;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_grant;
   logic              req0_done;

   logic              req1_valid;
   logic              req1_write;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_grant;
   logic              req1_done;

   logic [DATA_W-1:0] rdata;

   modport master (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req0_grant, req0_done, req1_grant, req1_done,
      input  rdata
   );

   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req0_grant, req0_done, req1_grant, req1_done,
      output rdata
   );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational two-way round-robin picker: a lone request always wins, a tie goes
// to the port that did not win last.
module rr_arbiter_2
   import ram_arb_pkg::*;
(
   input  logic   valid0,
   input  logic   valid1,
   input  owner_t last_owner,
   output logic   any_valid,
   output owner_t winner
);

   always_comb begin
      any_valid = valid0 | valid1;
      winner    = PORT0;
      if (valid0 && valid1) begin
         winner = (last_owner == PORT0) ? PORT1 : PORT0;
      end else if (valid1) begin
         winner = PORT1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port front end for the 512x32 async-read data RAM: round-robin arbitration,
// strobe sequencing with WAIT_CYCLES wait states. Optional write protect: RAM_ARB_WPROT_EN.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
`ifdef RAM_ARB_WPROT_EN
   ,
   parameter logic [ADDR_W-1:0] WPROT_LIMIT = 9'h080
`endif
) (
   input  logic              clock,
   input  logic              clear,
   ram_arbiter_if.slave      bus,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              wp_fault
);

   localparam int             CNT_W    = cnt_width(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

   state_t            state;
   state_t            state_nxt;
   owner_t            owner_q;
   owner_t            last_owner;
   owner_t            winner;
   logic              any_valid;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rdata_q;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              wp_block;
   logic              in_access;
   logic              first_cycle;

   rr_arbiter_2 u_rr (
      .valid0     (bus.req0_valid),
      .valid1     (bus.req1_valid),
      .last_owner (last_owner),
      .any_valid  (any_valid),
      .winner     (winner)
   );

   always_comb begin
      sel_write = bus.req0_write;
      sel_addr  = bus.req0_addr;
      sel_wdata = bus.req0_wdata;
      if (winner == PORT1) begin
         sel_write = bus.req1_write;
         sel_addr  = bus.req1_addr;
         sel_wdata = bus.req1_wdata;
      end
   end

`ifdef RAM_ARB_WPROT_EN
   assign wp_block = write_q && (addr_q < WPROT_LIMIT);
`else
   assign wp_block = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Strobes and pulses decode straight from state so an async clear removes them at once.
   always_comb begin
      state_nxt       = state;
      in_access       = (state == ACCESS);
      first_cycle     = in_access && (cnt == CNT_INIT);
      bus.req0_grant  = 1'b0;
      bus.req1_grant  = 1'b0;
      bus.req0_done   = 1'b0;
      bus.req1_done   = 1'b0;
      ram_read        = 1'b0;
      ram_write       = 1'b0;
      wp_fault        = 1'b0;
      busy            = (state != IDLE);
      case (state)
         IDLE: begin
            if (any_valid) state_nxt = ACCESS;
         end
         ACCESS: begin
            bus.req0_grant = first_cycle && (owner_q == PORT0);
            bus.req1_grant = first_cycle && (owner_q == PORT1);
            ram_read       = !write_q;
            ram_write      = write_q && !wp_block;
            if (cnt == '0) state_nxt = COMPLETE;
         end
         COMPLETE: begin
            bus.req0_done = (owner_q == PORT0);
            bus.req1_done = (owner_q == PORT1);
            wp_fault      = wp_block;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         owner_q    <= PORT0;
         last_owner <= PORT1;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
         rdata_q    <= '0;
      end else begin
         if (state == IDLE && any_valid) begin
            owner_q    <= winner;
            last_owner <= winner;
            write_q    <= sel_write;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            cnt        <= CNT_INIT;
         end
         if (state == ACCESS) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else if (!write_q) begin
               rdata_q <= ram_rdata;
            end
         end
      end
   end

   assign ram_address = addr_q;
   assign ram_wdata   = wdata_q;
   assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=0, each against a behavioural 512x32 async-read RAM.
module tb_ram_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   logic clock = 1'b0;
   logic clear = 1'b1;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_z ();

   logic          ram_read, ram_write, busy, wp_fault;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic          ram_read_z, ram_write_z, busy_z, wp_fault_z;
   logic [AW-1:0] ram_address_z;
   logic [DW-1:0] ram_wdata_z, ram_rdata_z;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
      .clock(clock), .clear(clear), .bus(bus),
      .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .wp_fault(wp_fault)
   );

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_z (
      .clock(clock), .clear(clear), .bus(bus_z),
      .ram_read(ram_read_z), .ram_write(ram_write_z), .ram_address(ram_address_z),
      .ram_wdata(ram_wdata_z), .ram_rdata(ram_rdata_z), .busy(busy_z), .wp_fault(wp_fault_z)
   );

   // RAM models plus a preload port used only while the arbiters are idle
   logic [DW-1:0] mem   [512];
   logic [DW-1:0] mem_z [512];
   logic          pl_en   = 1'b0;
   logic          pl_z    = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   assign ram_rdata   = mem[ram_address];
   assign ram_rdata_z = mem_z[ram_address_z];

   always @(posedge clock) begin
      if (ram_write)         mem[ram_address]     <= ram_wdata;
      if (ram_write_z)       mem_z[ram_address_z] <= ram_wdata_z;
      if (pl_en && !pl_z)    mem[pl_addr]         <= pl_data;
      if (pl_en && pl_z)     mem_z[pl_addr]       <= pl_data;
   end

   // Protocol monitor: strobe exclusivity and address/data stability under a strobe
   int            both_hi  = 0;
   int            unstable = 0;
   logic          prev_strobe = 1'b0;
   logic [AW-1:0] prev_a = '0;
   logic [DW-1:0] prev_d = '0;

   always @(negedge clock) begin
      if (ram_read && ram_write) both_hi++;
      if (ram_read_z && ram_write_z) both_hi++;
      if ((ram_read || ram_write) && prev_strobe &&
          (ram_address !== prev_a || ram_wdata !== prev_d)) unstable++;
      prev_strobe = ram_read || ram_write;
      prev_a      = ram_address;
      prev_d      = ram_wdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic z, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_z    = z;
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      tick();
      pl_en   = 1'b0;
   endtask

   // One request on the WAIT_CYCLES=1 instance; returns at the negedge of the done cycle.
   task automatic access(input bit port, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat, output int rdc,
                         output int wrc, output bit ok);
      lat = 0; rdc = 0; wrc = 0; ok = 1'b0;
      if (port) begin
         bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
      end
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         ok = port ? bus.req1_grant : bus.req0_grant;
      end
      if (port) bus.req1_valid = 1'b0;
      else      bus.req0_valid = 1'b0;
      if (ok) begin
         rdc += int'(ram_read);
         wrc += int'(ram_write);
         ok = 1'b0;
         for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            lat++;
            rdc += int'(ram_read);
            wrc += int'(ram_write);
            ok = port ? bus.req1_done : bus.req0_done;
         end
      end
   endtask

   int         lat, rdc, wrc, ng, d0, d1, rd_bad, nd;
   bit         ok;
   logic [3:0] order;
   int         gcyc [4];
   logic [DW-1:0] wp_exp;

   initial begin
      bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
      bus_z.req0_valid = 0; bus_z.req0_write = 0; bus_z.req0_addr = '0; bus_z.req0_wdata = '0;
      bus_z.req1_valid = 0; bus_z.req1_write = 0; bus_z.req1_addr = '0; bus_z.req1_wdata = '0;
      order = '0;
      gcyc  = '{default: 0};

      // Reset state
      #2 clear = 1'b0;
      tick(); tick();
      chk("rst_grant", {bus.req0_grant, bus.req1_grant}, 0);
      chk("rst_done", {bus.req0_done, bus.req1_done}, 0);
      chk("rst_strobes", {ram_read, ram_write}, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_address", ram_address, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_busy_wpf", {busy, wp_fault}, 0);
      clear = 1'b1;
      tick();

      // 1: port 0 read of RAM[5], cycle by cycle
      preload(1'b0, 9'h005, 32'hDEADBEEF);
      bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 9'h005;
      tick();
      chk("t1_grant", bus.req0_grant, 1);
      chk("t1_read_c1", {ram_read, ram_write}, 2'b10);
      chk("t1_addr", ram_address, 9'h005);
      bus.req0_valid = 1'b0;
      tick();
      chk("t1_read_c2", {ram_read, bus.req0_grant, bus.req0_done}, 3'b100);
      tick();
      chk("t1_done", {bus.req0_done, ram_read, busy}, 3'b101);
      chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
      tick();
      chk("t1_idle", {busy, bus.req0_done}, 0);
      chk("t1_rdata_held", bus.rdata, 32'hDEADBEEF);

      // 2: port 1 write then readback via port 0
      access(1'b1, 1'b1, 9'h1F0, 32'h12345678, lat, rdc, wrc, ok);
      chk("t2_complete", ok, 1);
      chk("t2_latency", lat, 2);
      chk("t2_strobes", {rdc[7:0], wrc[7:0]}, 16'h0002);
      chk("t2_wpf", wp_fault, 0);
      tick();
      chk("t2_mem", mem[9'h1F0], 32'h12345678);
      access(1'b0, 1'b0, 9'h1F0, 32'h0, lat, rdc, wrc, ok);
      chk("t2_readback", bus.rdata, 32'h12345678);
      tick();
      chk("t2_addr_held", ram_address, 9'h1F0);

      // 3: both ports request continuously after a fresh reset
      clear = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      ng = 0; d0 = 0; d1 = 0; rd_bad = 0;
      bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 9'h005;
      bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 9'h1F0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (bus.req0_grant || bus.req1_grant) begin
            if (ng < 4) begin
               order[3-ng] = bus.req1_grant;
               gcyc[ng]    = c;
            end
            ng++;
            if (ng == 4) begin
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
         end
         if (bus.req0_done) begin
            d0++;
            if (bus.rdata !== 32'hDEADBEEF) rd_bad++;
         end
         if (bus.req1_done) begin
            d1++;
            if (bus.rdata !== 32'h12345678) rd_bad++;
         end
      end
      chk("t3_grants", ng, 4);
      chk("t3_order", order, 4'b0101);
      chk("t3_done0", d0, 2);
      chk("t3_done1", d1, 2);
      chk("t3_rdata", rd_bad, 0);
      chk("t3_spacing", gcyc[1] - gcyc[0], 4);

      // 4: clear in the middle of a write access
      bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 9'h033;
      bus.req0_wdata = 32'hAAAA5555;
      tick();
      chk("t4_write_hi", ram_write, 1);
      bus.req0_valid = 1'b0;
      #2 clear = 1'b0;
      #1;
      chk("t4_write_drop", {ram_write, ram_read}, 0);
      chk("t4_busy", busy, 0);
      tick();
      clear = 1'b1;
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         nd += int'(bus.req0_done) + int'(bus.req0_grant);
      end
      chk("t4_no_done", nd, 0);
      access(1'b1, 1'b0, 9'h1F0, 32'h0, lat, rdc, wrc, ok);
      chk("t4_next_lat", lat, 2);
      chk("t4_next_rdata", bus.rdata, 32'h12345678);

      // 5: zero wait states
      preload(1'b1, 9'h007, 32'hCAFEF00D);
      bus_z.req0_valid = 1'b1; bus_z.req0_write = 1'b0; bus_z.req0_addr = 9'h007;
      tick();
      chk("t5_grant", {bus_z.req0_grant, ram_read_z}, 2'b11);
      bus_z.req0_valid = 1'b0;
      tick();
      chk("t5_done", {bus_z.req0_done, ram_read_z}, 2'b10);
      chk("t5_rdata", bus_z.rdata, 32'hCAFEF00D);
      tick();
      chk("t5_idle", busy_z, 0);

      // 6: write below the protect boundary, then above it
      preload(1'b0, 9'h010, 32'h11111111);
`ifdef RAM_ARB_WPROT_EN
      wp_exp = 32'h11111111;
      access(1'b0, 1'b1, 9'h010, 32'h55AA55AA, lat, rdc, wrc, ok);
      chk("t6_low_wrc", wrc, 0);
      chk("t6_low_done_wpf", {bus.req0_done, wp_fault}, 2'b11);
`else
      wp_exp = 32'h55AA55AA;
      access(1'b0, 1'b1, 9'h010, 32'h55AA55AA, lat, rdc, wrc, ok);
      chk("t6_low_wrc", wrc, 2);
      chk("t6_low_done_wpf", {bus.req0_done, wp_fault}, 2'b10);
`endif
      tick();
      chk("t6_low_mem", mem[9'h010], wp_exp);
      access(1'b1, 1'b1, 9'h100, 32'h0F0F0F0F, lat, rdc, wrc, ok);
      chk("t6_high_wrc", wrc, 2);
      chk("t6_high_done_wpf", {bus.req1_done, wp_fault}, 2'b10);
      tick();
      chk("t6_high_mem", mem[9'h100], 32'h0F0F0F0F);

      chk("never_both_strobes", both_hi, 0);
      chk("addr_data_stable", unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
